// File: rtl/ssp_pkg.sv
// Shared sizing constants for the SSP transmit path.
package ssp_pkg;

  localparam int unsigned SSP_WORD_W        = 8;
  localparam int unsigned SSP_TX_FIFO_DEPTH = 4;
  localparam int unsigned SSP_TX_PTR_W      = $clog2(SSP_TX_FIFO_DEPTH);

endpackage

// File: rtl/ssp_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port, no reset.
module ssp_fifo_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: show-ahead head word to the serializer, full/empty decoded from
// an occupancy counter, sticky overflow on writes dropped while full.
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int unsigned WIDTH = SSP_WORD_W,
  parameter int unsigned DEPTH = SSP_TX_FIFO_DEPTH
) (
  input  logic             PCLK,
  input  logic             CLEAR,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic [WIDTH-1:0] PWDATA,
  input  logic             TxNextWord,
  output logic [WIDTH-1:0] TxData,
  output logic             TxValidWord,
  output logic             TxIsEmpty,
  output logic             SSPTXINTR,
  output logic             TxOverflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             wr_req, full, empty, push, pop;
  logic [WIDTH-1:0] head_word;

  assign wr_req = PSEL & PWRITE;
  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // Both qualifiers use the pre-edge count, so push+pop on empty keeps only the push.
  assign push   = wr_req & ~full;
  assign pop    = TxNextWord & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_req & full);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  ssp_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (PCLK),
    .we_i    (push & ~CLEAR),
    .waddr_i (wr_ptr_q),
    .wdata_i (PWDATA),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_word)
  );

  // Storage is never reset, so the head word is masked whenever the queue is empty.
  assign TxData      = empty ? '0 : head_word;
  assign TxValidWord = ~empty;
  assign TxIsEmpty   = empty;
  assign SSPTXINTR   = full;
  assign TxOverflow  = ovf_q;

endmodule

// File: doc/ssp_tx_fifo.md
SSP_TX_FIFO -- requirements
Module: ssp_tx_fifo

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 4, meaning number of stored words; power of two only.
REQ-003 SHALL provide port PCLK  input  1  system clock; every register updates on its rising edge.
REQ-004 SHALL provide port CLEAR  input  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL provide port PSEL  input  1  processor select for a FIFO write.
REQ-006 SHALL provide port PWRITE  input  1  processor write strobe, qualified by PSEL.
REQ-007 SHALL provide port PWDATA  input  WIDTH  processor write data.
REQ-008 SHALL provide port TxNextWord  input  1  single-PCLK pop request from the serializer.
REQ-009 SHALL provide port TxData  output  WIDTH  head-of-queue word presented to the serializer.
REQ-010 SHALL provide port TxValidWord  output  1  TxData holds a valid word.
REQ-011 SHALL provide port TxIsEmpty  output  1  FIFO holds zero words.
REQ-012 SHALL provide port SSPTXINTR  output  1  FIFO full; processor must not write.
REQ-013 SHALL provide port TxOverflow  output  1  sticky flag: a write was dropped while full.

Function
REQ-014 push = PSEL && PWRITE && (count != DEPTH); the accepted word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-015 pop = TxNextWord && (count != 0); rd_ptr increments modulo DEPTH.
REQ-016 count SHALL be log2(DEPTH)+1 bits wide, range 0..DEPTH. It is +1 on push only, -1 on pop only, and unchanged on push and pop in the same cycle.
REQ-017 Full and empty SHALL be decoded from count, never from pointer equality alone.
REQ-018 Show-ahead read: TxData = mem[rd_ptr] combinationally, zero-cycle latency. The serializer samples TxData in the same cycle it asserts TxNextWord.
REQ-019 When empty, TxData SHALL be driven to all zeros.
REQ-020 TxValidWord = (count != 0); TxIsEmpty = (count == 0). Both are combinational from registered count.
REQ-021 SSPTXINTR = (count == DEPTH), combinational from registered count.
REQ-022 Write while full SHALL be dropped: no pointer or data change, and TxOverflow sets on the next edge. This holds even if a pop occurs in the same cycle.
REQ-023 With count == 0, simultaneous push and pop SHALL accept the push and ignore the pop, because pop is qualified by pre-edge count.
REQ-024 Pop while empty SHALL be ignored with no flag raised.
REQ-025 Write latency SHALL be one cycle: a word pushed at edge N is visible on TxData after edge N when the FIFO was empty.
REQ-026 TxOverflow SHALL remain high until CLEAR.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with FIFO order preserved across the wrap.

Reset
REQ-028 On a PCLK edge with CLEAR = 1, the block SHALL set wr_ptr = 0, rd_ptr = 0, count = 0 and TxOverflow = 0.
REQ-029 Outputs after reset SHALL be TxIsEmpty = 1, TxValidWord = 0, SSPTXINTR = 0, TxData = 0 and TxOverflow = 0.
REQ-030 CLEAR SHALL take priority over simultaneous push or pop, and any queued words are discarded.
REQ-031 Storage array contents need not be reset; TxData is masked by empty (REQ-019).

Structure
REQ-032 Package ssp_pkg SHALL hold SSP_WORD_W = 8, SSP_TX_FIFO_DEPTH = 4 and the derived pointer width SSP_TX_PTR_W = 2.
REQ-033 Sub-module ssp_fifo_mem SHALL hold the register array: one synchronous write port and one asynchronous read port, with no reset.
REQ-034 Pointer, count and flag logic SHALL reside in ssp_tx_fifo.

Verification
REQ-035 Reset, then idle -> TxIsEmpty = 1, TxValidWord = 0, SSPTXINTR = 0, TxData = 8'h00.
REQ-036 Write 8'hA5 while empty, then one cycle -> TxData = 8'hA5, TxValidWord = 1; pulse TxNextWord -> TxIsEmpty = 1 on the next cycle.
REQ-037 Write 8'h11, 22, 33, 44 -> SSPTXINTR = 1. Then write 8'h55 -> dropped and TxOverflow = 1. Then four pops -> order 11, 22, 33, 44.
REQ-038 Wrap test:
- Write 3 words and pop 3 words, so both pointers sit at 3.
- Write 8'hC1, C2, C3.
- Required: pops return C1, C2, C3 in order across the wrap.
REQ-039 Simultaneous events:
- With count = 2, assert push and pop in the same cycle -> count stays 2 and head advances.
- With count = 0, assert push and pop together -> count becomes 1.
REQ-040 Assert CLEAR mid-stream with count = 3 -> all flags return to their reset values next cycle and the old data is never presented.
